// File: rtl/pe_smem_drain_if.sv
// Bus bundle between the mesh shared-memory egress FIFOs, the drain
// engine and the scratchpad write port. The drain engine is the master:
// it issues dequeue strobes and scratchpad writes.
interface pe_smem_drain_if #(
    parameter int NPORT  = 4,
    parameter int PKT_W  = 36,
    parameter int ADDR_W = 10
);
    logic [NPORT-1:0]            smem_out_empty;
    logic [NPORT-1:0][PKT_W-1:0] smem_out_rdata;
    logic [NPORT-1:0]            smem_out_deq;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [PKT_W-1:0]            wr_data;
    logic                        wr_ready;

    modport master (
        input  smem_out_empty,
        input  smem_out_rdata,
        input  wr_ready,
        output smem_out_deq,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output smem_out_empty,
        output smem_out_rdata,
        output wr_ready,
        input  smem_out_deq,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/pe_smem_drain.sv
// Drains the mesh shared-memory egress FIFOs with round-robin arbitration
// (at most one packet per cycle) into a scratchpad write port. Each port
// owns one address quadrant selected by the top two address bits. Packets
// are counted against a programmed total; done is raised once the total
// has been accepted by the scratchpad.
module pe_smem_drain #(
    parameter int NPORT  = 4,
    parameter int PKT_W  = 36,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pe_smem_drain_if.master  bus,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             busy,
    output logic             done,
    output logic [NPORT-1:0] ovf
);
    localparam int PTR_W = ADDR_W - 2;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_MAX  = {PTR_W{1'b1}};
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  issued_r;
    logic [CNT_W-1:0]  accepted_r;
    logic [1:0]        rr_r;
    logic [PTR_W-1:0]  ptr_r [NPORT];
    logic [NPORT-1:0]  ovf_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [PKT_W-1:0]  wr_data_r;

    logic              slot_free_s;
    logic              accept_s;
    logic              last_accept_s;
    logic              deq_go_s;
    logic              start_run_s;
    logic              found_s;
    logic [1:0]        sel_s;
    logic [1:0]        scan_idx_s;
    logic [NPORT-1:0]  deq_s;

    // Round-robin scan: first non-empty port starting at rr_r, wrapping mod 4.
    always_comb begin
        sel_s      = rr_r;
        found_s    = 1'b0;
        scan_idx_s = rr_r;
        for (int i = 0; i < NPORT; i++) begin
            scan_idx_s = rr_r + 2'(i);
            if (!found_s && !bus.smem_out_empty[scan_idx_s]) begin
                found_s = 1'b1;
                sel_s   = scan_idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Issue/accept qualification and the combinational dequeue strobe.
    always_comb begin
        slot_free_s   = !wr_en_r || bus.wr_ready;
        accept_s      = wr_en_r && bus.wr_ready;
        last_accept_s = accept_s && ((accepted_r + CNT_ONE) == count_r);
        deq_go_s      = (state_r == ST_RUN) && slot_free_s &&
                        (issued_r < count_r) && found_s;
        start_run_s   = ((state_r == ST_IDLE) || (state_r == ST_DONE)) &&
                        cfg_start && (cfg_count != CNT_ZERO);
        deq_s         = {NPORT{1'b0}};
        if (deq_go_s) begin
            deq_s[sel_s] = 1'b1;
        end else begin
            deq_s = {NPORT{1'b0}};
        end
    end

    // Next-state logic; cfg_start is ignored while a drain is running.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    state_nxt_s = (cfg_count != CNT_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (last_accept_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Drain bookkeeping: counters, round-robin pointer, per-port pointers, sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= CNT_ZERO;
            issued_r   <= CNT_ZERO;
            accepted_r <= CNT_ZERO;
            rr_r       <= 2'd0;
            ovf_r      <= {NPORT{1'b0}};
            for (int p = 0; p < NPORT; p++) begin
                ptr_r[p] <= PTR_ZERO;
            end
        end else if (start_run_s) begin
            // ovf survives a restart on purpose; only reset clears it
            count_r    <= cfg_count;
            issued_r   <= CNT_ZERO;
            accepted_r <= CNT_ZERO;
            rr_r       <= 2'd0;
            for (int p = 0; p < NPORT; p++) begin
                ptr_r[p] <= PTR_ZERO;
            end
        end else begin
            if (deq_go_s) begin
                issued_r     <= issued_r + CNT_ONE;
                rr_r         <= sel_s + 2'd1;
                ptr_r[sel_s] <= ptr_r[sel_s] + PTR_ONE;
                if (ptr_r[sel_s] == PTR_MAX) begin
                    ovf_r[sel_s] <= 1'b1;
                end
            end
            if (accept_s) begin
                accepted_r <= accepted_r + CNT_ONE;
            end
        end
    end

    // Registered write slot: load on dequeue, hold under backpressure, drop on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {PKT_W{1'b0}};
        end else if (deq_go_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= {sel_s, ptr_r[sel_s]};
            wr_data_r <= bus.smem_out_rdata[sel_s];
        end else if (accept_s) begin
            wr_en_r   <= 1'b0;
        end
    end

    assign bus.smem_out_deq = deq_s;
    assign bus.wr_en        = wr_en_r;
    assign bus.wr_addr      = wr_addr_r;
    assign bus.wr_data      = wr_data_r;
    assign busy             = (state_r == ST_RUN);
    assign done             = (state_r == ST_DONE);
    assign ovf              = ovf_r;

endmodule

// File: tb/tb_pe_smem_drain.sv
// Bench for pe_smem_drain: mesh FIFOs modelled as queues, a cycle-level
// reference model built from the drain rules, table-driven scenarios,
// hand-written corner sequences and randomized scenarios. A second,
// narrow-address instance exercises pointer wrap.
module tb_pe_smem_drain;
    localparam int NPORT = 4, PKT_W = 36, ADDR_W = 10, CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             cfg_start;
    logic [CNT_W-1:0] cfg_count;
    logic             busy, done;
    logic [3:0]       ovf;

    pe_smem_drain_if #(.NPORT(NPORT), .PKT_W(PKT_W), .ADDR_W(ADDR_W)) bus ();
    pe_smem_drain #(.NPORT(NPORT), .PKT_W(PKT_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cfg_start(cfg_start), .cfg_count(cfg_count),
        .busy(busy), .done(done), .ovf(ovf));

    logic             cfg_start_s;
    logic [CNT_W-1:0] cfg_count_s;
    logic             busy_s, done_s;
    logic [3:0]       ovf_s;

    pe_smem_drain_if #(.NPORT(NPORT), .PKT_W(PKT_W), .ADDR_W(4)) bus_s ();
    pe_smem_drain #(.NPORT(NPORT), .PKT_W(PKT_W), .ADDR_W(4), .CNT_W(CNT_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .cfg_start(cfg_start_s), .cfg_count(cfg_count_s),
        .busy(busy_s), .done(done_s), .ovf(ovf_s));

    int n_chk = 0;
    int n_err = 0;

    // mesh FIFO contents and reference model state
    logic [PKT_W-1:0] fq [4][$];
    int               m_st;       // 0 idle, 1 run, 2 done
    int               m_rr, m_issued, m_acc, m_count;
    int               m_ptr [4];
    bit               m_wen;
    logic [9:0]       m_addr;
    logic [35:0]      m_data;
    logic [3:0]       m_ovf;
    logic [3:0]       pend_pop;
    int               pkt_tag = 0;
    int               n_deq_dut;
    logic [9:0]       acc_addrs [$];
    int               deq_order [$];

    logic [PKT_W-1:0] s_q [$];
    logic [3:0]       s_addrs [$];

    typedef struct packed {
        logic [7:0]  f0, f1, f2, f3;
        logic [15:0] cnt;
        logic [7:0]  bp_at, bp_len;
        logic        rnd;
        logic [15:0] exp_deq, exp_left;
        logic        exp_done;
    } scn_t;

    scn_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic scn_t mk(input int f0, input int f1, input int f2, input int f3,
                                input int cnt, input int bp_at, input int bp_len, input bit rnd,
                                input int e_deq, input int e_left, input bit e_done);
        scn_t s;
        s.f0 = 8'(f0); s.f1 = 8'(f1); s.f2 = 8'(f2); s.f3 = 8'(f3);
        s.cnt = 16'(cnt); s.bp_at = 8'(bp_at); s.bp_len = 8'(bp_len); s.rnd = rnd;
        s.exp_deq = 16'(e_deq); s.exp_left = 16'(e_left); s.exp_done = e_done;
        return s;
    endfunction

    function automatic int fifo_total();
        int t = 0;
        for (int p = 0; p < 4; p++) t += fq[p].size();
        return t;
    endfunction

    task automatic push_pkt(input int p);
        logic [PKT_W-1:0] d;
        pkt_tag++;
        d = {pkt_tag[15:0], 20'($urandom_range(0, 1048575))};
        fq[p].push_back(d);
    endtask

    task automatic drive_fifo();
        for (int p = 0; p < 4; p++) begin
            bus.smem_out_empty[p] = (fq[p].size() == 0);
            bus.smem_out_rdata[p] = (fq[p].size() != 0) ? fq[p][0] : 36'd0;
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_rr = 0; m_issued = 0; m_acc = 0; m_count = 0;
        m_wen = 1'b0; m_addr = 10'd0; m_data = 36'd0; m_ovf = 4'd0; pend_pop = 4'd0;
        for (int p = 0; p < 4; p++) m_ptr[p] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_count = 16'd0; bus.wr_ready = 1'b1;
        cfg_start_s = 1'b0; cfg_count_s = 16'd0; bus_s.wr_ready = 1'b1;
        bus_s.smem_out_empty = 4'hF; bus_s.smem_out_rdata = '0;
        for (int p = 0; p < 4; p++) fq[p].delete();
        s_q.delete(); s_addrs.delete();
        drive_fifo();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock of the main DUT: drive, predict, compare at negedge, pop after the edge.
    task automatic cycle(input bit start, input int cnt, input bit rdy);
        int sel, idx;
        bit acc;
        logic [3:0] exp_deq, got_deq;
        cfg_start = start; cfg_count = cnt[15:0]; bus.wr_ready = rdy;
        drive_fifo();
        @(negedge clk);
        sel = -1;
        exp_deq = 4'd0;
        if (m_st == 1 && (!m_wen || rdy) && m_issued < m_count)
            for (int i = 0; i < 4; i++) begin
                idx = (m_rr + i) % 4;
                if (sel < 0 && fq[idx].size() != 0) sel = idx;
            end
        if (sel >= 0) exp_deq[sel] = 1'b1;
        got_deq = bus.smem_out_deq;
        chk("deq", got_deq, exp_deq);
        chk("wr_en", bus.wr_en, m_wen);
        if (m_wen) begin
            chk("wr_addr", bus.wr_addr, m_addr);
            chk("wr_data", bus.wr_data, m_data);
        end
        chk("busy", busy, m_st == 1);
        chk("done", done, m_st == 2);
        chk("ovf", ovf, m_ovf);
        n_deq_dut += $countones(got_deq);
        for (int p = 0; p < 4; p++) if (got_deq[p]) deq_order.push_back(p);
        if (bus.wr_en && rdy) acc_addrs.push_back(bus.wr_addr);
        // advance the reference model by one clock
        acc = m_wen && rdy;
        if (m_st == 1) begin
            if (acc) m_acc++;
            if (sel >= 0) begin
                m_wen  = 1'b1;
                m_addr = {sel[1:0], m_ptr[sel][7:0]};
                m_data = fq[sel][0];
                if (m_ptr[sel] == 255) begin m_ptr[sel] = 0; m_ovf[sel] = 1'b1; end
                else m_ptr[sel]++;
                m_issued++;
                m_rr = (sel + 1) % 4;
            end else if (acc) m_wen = 1'b0;
            if (acc && m_acc == m_count) m_st = 2;
        end else if (start) begin
            if (cnt != 0) begin
                m_st = 1; m_count = cnt; m_issued = 0; m_acc = 0; m_rr = 0;
                for (int p = 0; p < 4; p++) m_ptr[p] = 0;
            end else m_st = 2;
        end
        pend_pop = got_deq;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++)
            if (pend_pop[p] && fq[p].size() != 0) void'(fq[p].pop_front());
        pend_pop = 4'd0;
    endtask

    task automatic run_scn(input scn_t s);
        int idle;
        bit rdy;
        do_reset();
        for (int i = 0; i < s.f0; i++) push_pkt(0);
        for (int i = 0; i < s.f1; i++) push_pkt(1);
        for (int i = 0; i < s.f2; i++) push_pkt(2);
        for (int i = 0; i < s.f3; i++) push_pkt(3);
        n_deq_dut = 0; acc_addrs.delete(); deq_order.delete();
        cycle(1'b1, int'(s.cnt), 1'b1);
        idle = 0;
        for (int c = 0; c < 400; c++) begin
            rdy = 1'b1;
            if (c >= int'(s.bp_at) && c < int'(s.bp_at) + int'(s.bp_len)) rdy = 1'b0;
            else if (s.rnd) rdy = 1'($urandom_range(0, 1));
            cycle(1'b0, int'(s.cnt), rdy);
            if (m_st == 2) begin
                cycle(1'b0, int'(s.cnt), 1'b1);
                break;
            end
            if (fifo_total() == 0 && !m_wen) idle++;
            if (idle > 4) break;
        end
        chk("scn_deq", n_deq_dut, s.exp_deq);
        chk("scn_left", fifo_total(), s.exp_left);
        chk("scn_done", done, s.exp_done);
    endtask

    // Pointer wrap on the narrow-address instance: 5 packets on port 1.
    task automatic t6_wrap();
        logic [3:0] sd;
        int others;
        for (int i = 0; i < 5; i++) s_q.push_back(36'(i + 100));
        others = 0;
        for (int c = 0; c < 25; c++) begin
            cfg_start_s = (c == 0); cfg_count_s = 16'd5; bus_s.wr_ready = 1'b1;
            bus_s.smem_out_empty = {1'b1, 1'b1, (s_q.size() == 0), 1'b1};
            bus_s.smem_out_rdata[1] = (s_q.size() != 0) ? s_q[0] : 36'd0;
            @(negedge clk);
            sd = bus_s.smem_out_deq;
            if ((sd & 4'b1101) != 4'd0) others++;
            if (bus_s.wr_en && bus_s.wr_ready) s_addrs.push_back(bus_s.wr_addr);
            @(posedge clk);
            #1;
            if (sd[1] && s_q.size() != 0) void'(s_q.pop_front());
        end
        chk("t6_nwrites", s_addrs.size(), 5);
        for (int i = 0; i < s_addrs.size() && i < 5; i++)
            chk("t6_addr", s_addrs[i], 4'(4 + (i % 4)));
        chk("t6_ovf", ovf_s, 4'b0010);
        chk("t6_done", done_s, 1'b1);
        chk("t6_left", s_q.size(), 0);
        chk("t6_other_deq", others, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int f [4];
        int tot, cnt, e_deq;
        tbl[0] = mk(0, 0, 3, 0, 3, 0, 0, 1'b0, 3, 0, 1'b1);   // single port 2
        tbl[1] = mk(2, 2, 2, 2, 8, 0, 0, 1'b0, 8, 0, 1'b1);   // round robin
        tbl[2] = mk(2, 2, 2, 2, 8, 3, 5, 1'b0, 8, 0, 1'b1);   // backpressure
        tbl[3] = mk(4, 0, 0, 0, 2, 0, 0, 1'b0, 2, 2, 1'b1);   // count limit
        tbl[4] = mk(1, 0, 3, 2, 10, 0, 0, 1'b0, 6, 0, 1'b0);  // count never reached
        tbl[5] = mk(3, 1, 0, 5, 9, 2, 3, 1'b1, 9, 0, 1'b1);   // mixed with random ready

        // reset values
        do_reset();
        #1;
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, 10'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf, 4'd0);
        chk("rst_ovf_s", ovf_s, 4'd0);

        // reset asserted mid-run while a write is held under backpressure
        do_reset();
        for (int i = 0; i < 4; i++) push_pkt(0);
        cycle(1'b1, 4, 1'b0);
        cycle(1'b0, 4, 1'b0);
        cycle(1'b0, 4, 1'b0);
        chk("t1_pre_wr_en", bus.wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t1_wr_en", bus.wr_en, 1'b0);
        chk("t1_wr_addr", bus.wr_addr, 10'd0);
        chk("t1_wr_data", bus.wr_data, 36'd0);
        chk("t1_deq", bus.smem_out_deq, 4'd0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_done", done, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 4, 1'b1);
        cycle(1'b0, 4, 1'b1);
        chk("t1_left", fifo_total(), 3);

        // table-driven scenarios
        for (int i = 0; i < 6; i++) begin
            run_scn(tbl[i]);
            if (i == 0) begin
                chk("t2_nacc", acc_addrs.size(), 3);
                for (int k = 0; k < acc_addrs.size() && k < 3; k++)
                    chk("t2_addr", acc_addrs[k], 10'h200 + 10'(k));
            end
            if (i == 1) begin
                chk("t3_ndeq", deq_order.size(), 8);
                for (int k = 0; k < deq_order.size() && k < 8; k++)
                    chk("t3_order", deq_order[k], k % 4);
            end
        end

        // zero count goes straight to done, then restart from done
        do_reset();
        push_pkt(3); push_pkt(3);
        n_deq_dut = 0; acc_addrs.delete();
        cycle(1'b1, 0, 1'b1);
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b1);
        chk("t6z_done", done, 1'b1);
        chk("t6z_ndeq", n_deq_dut, 0);
        cycle(1'b1, 2, 1'b1);
        for (int c = 0; c < 10; c++) cycle(1'b0, 2, 1'b1);
        chk("t6z_restart_done", done, 1'b1);
        chk("t6z_left", fifo_total(), 0);
        chk("t6z_nacc", acc_addrs.size(), 2);
        if (acc_addrs.size() == 2) begin
            chk("t6z_addr0", acc_addrs[0], 10'h300);
            chk("t6z_addr1", acc_addrs[1], 10'h301);
        end

        // pointer wrap on the narrow instance
        do_reset();
        t6_wrap();

        // randomized scenarios; totals follow from min(count, queued)
        for (int r = 0; r < 10; r++) begin
            tot = 0;
            for (int p = 0; p < 4; p++) begin
                f[p] = $urandom_range(0, 5);
                tot += f[p];
            end
            cnt = $urandom_range(0, 25);
            e_deq = (cnt < tot) ? cnt : tot;
            run_scn(mk(f[0], f[1], f[2], f[3], cnt, $urandom_range(0, 6), $urandom_range(0, 4),
                       1'b1, e_deq, tot - e_deq, cnt <= tot));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
